// File: rtl/speck_pkg.sv
// speck_pkg: shared FSM state type and SPECK128/128 constants
// for the iterative round sequencer and its watchdog.
package speck_pkg;

    localparam int WORD_W     = 64;
    localparam int BLOCK_W    = 128;
    localparam int DEF_ROUNDS = 32;

    typedef enum logic [2:0] {
        IDLE,
        R_START,
        R_WAIT,
        K_START,
        K_WAIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/speck_seq_watchdog.sv
// speck_seq_watchdog: counts datapath wait cycles; expired when the
// limit is reached. Ports: clk, rst_n, clear, active -> expired.
`ifdef SPECK_SEQ_TIMEOUT_EN
module speck_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 255) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // count holds the number of wait cycles already spent, so the
    // limit-th wait cycle is the one that raises expired
    assign expired = active && (count == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (active && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/speck_round_sequencer.sv
// speck_round_sequencer: iterates external SPECK round / key-schedule
// datapaths over NUM_ROUNDS rounds behind a start/busy/done handshake.
// Ports: host (start, key, plaintext, busy, done, ciphertext, error),
// round datapath (round_*), key schedule datapath (ks_*).
// Optional watchdog enabled by defining SPECK_SEQ_TIMEOUT_EN.
module speck_round_sequencer
    import speck_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_ROUNDS
`ifdef SPECK_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] plaintext,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic               error,
    output logic               round_start,
    output logic [WORD_W-1:0]  round_subkey,
    output logic [BLOCK_W-1:0] round_in,
    input  logic [BLOCK_W-1:0] round_out,
    input  logic               round_finished,
    output logic               ks_start,
    output logic [BLOCK_W-1:0] ks_key_in,
    output logic [5:0]         ks_round,
    input  logic [BLOCK_W-1:0] ks_key_out,
    input  logic               ks_finished
);

    localparam int RC_W = $clog2(NUM_ROUNDS);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(NUM_ROUNDS - 1);

    seq_state_t state_q, state_d;

    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] ct_q, ct_d;
    logic [RC_W-1:0]    rc_q, rc_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rs_q, rs_d;
    logic               ks_q, ks_d;
    logic               wd_expired;

`ifdef SPECK_SEQ_TIMEOUT_EN
    speck_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((state_q == R_START) || (state_q == K_START)),
        .active ((state_q == R_WAIT) || (state_q == K_WAIT)),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        key_d   = key_q;
        ct_d    = ct_q;
        rc_d    = rc_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    blk_d   = plaintext;
                    key_d   = key;
                    rc_d    = '0;
                    err_d   = 1'b0;
                    state_d = R_START;
                end
            end
            R_START: state_d = R_WAIT;
            R_WAIT: begin
                // a real completion wins over a same-cycle timeout
                if (round_finished) begin
                    blk_d = round_out;
                    if (rc_q == RC_LAST) begin
                        ct_d    = round_out;
                        state_d = DONE;
                    end else begin
                        state_d = K_START;
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            K_START: state_d = K_WAIT;
            K_WAIT: begin
                if (ks_finished) begin
                    key_d   = ks_key_out;
                    rc_d    = rc_q + RC_W'(1);
                    state_d = R_START;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // handshake outputs are registered copies of the next state
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        rs_d   = (state_d == R_START);
        ks_d   = (state_d == K_START);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            blk_q   <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            rc_q    <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rs_q    <= 1'b0;
            ks_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            rc_q    <= rc_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rs_q    <= rs_d;
            ks_q    <= ks_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign ciphertext   = ct_q;
    assign error        = err_q;
    assign round_start  = rs_q;
    assign round_subkey = key_q[BLOCK_W-1:WORD_W];
    assign round_in     = blk_q;
    assign ks_start     = ks_q;
    assign ks_key_in    = key_q;
    assign ks_round     = 6'(rc_q);

endmodule
